// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter that serializes requests onto one registered AND/OR/XOR/NAND unit.
// One transaction takes IDLE -> EXEC -> DONE; ack and result_valid are decoded from DONE.
//
// state  | meaning
// S_IDLE | waiting for any req; winner picked from ptr upward, operands captured
// S_EXEC | logic unit evaluates the captured operands
// S_DONE | result_valid and ack to the served requester; pointer advances
module logic_unit_arbiter #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic [N*W-1:0]   a_in,
  input  logic [N*W-1:0]   b_in,
  input  logic [N*2-1:0]   op_in,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     ack,
  output logic [W-1:0]     result,
  output logic             result_valid,
  output logic [IDW-1:0]   result_id,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  localparam logic [N-1:0] ONE_HOT_0 = {{(N-1){1'b0}}, 1'b1};

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [1:0]     op_q, op_d;
  logic [W-1:0]   result_q, result_d;
  logic [IDW-1:0] result_id_q, result_id_d;

  logic           win_found;
  logic [IDW-1:0] win_idx;

  // Search starts at ptr and wraps, so the last served requester is checked last.
  always_comb begin
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N) j = j - N;
      if (!win_found && req[j]) begin
        win_found = 1'b1;
        win_idx   = IDW'(j);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    gnt_d       = gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    result_d    = result_q;
    result_id_d = result_id_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          a_d     = a_in[win_idx*W +: W];
          b_d     = b_in[win_idx*W +: W];
          op_d    = op_in[win_idx*2 +: 2];
          gnt_d   = ONE_HOT_0 << win_idx;
          id_d    = win_idx;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_q)
          2'b00:   result_d = a_q & b_q;
          2'b01:   result_d = a_q | b_q;
          2'b10:   result_d = a_q ^ b_q;
          default: result_d = ~(a_q & b_q);
        endcase
        result_id_d = id_q;
        state_d     = S_DONE;
      end
      S_DONE: begin
        gnt_d   = '0;
        ptr_d   = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      id_q        <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      result_q    <= '0;
      result_id_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      gnt_q       <= gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      result_q    <= result_d;
      result_id_q <= result_id_d;
    end
  end

  assign gnt          = gnt_q;
  assign ack          = (state_q == S_DONE) ? (ONE_HOT_0 << id_q) : '0;
  assign result_valid = (state_q == S_DONE);
  assign busy         = (state_q != S_IDLE);
  assign result       = result_q;
  assign result_id    = result_id_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: handshake timing, opcodes, fairness, wrap, capture, reset.
module tb_logic_unit_arbiter;
  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req;
  logic [N*W-1:0]   a_in;
  logic [N*W-1:0]   b_in;
  logic [N*2-1:0]   op_in;
  logic [N-1:0]     gnt;
  logic [N-1:0]     ack;
  logic [W-1:0]     result;
  logic             result_valid;
  logic [IDW-1:0]   result_id;
  logic             busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_unit_arbiter #(.N(N), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .a_in         (a_in),
    .b_in         (b_in),
    .op_in        (op_in),
    .gnt          (gnt),
    .ack          (ack),
    .result       (result),
    .result_valid (result_valid),
    .result_id    (result_id),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int i, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    a_in[i*W +: W]  = a;
    b_in[i*W +: W]  = b;
    op_in[i*2 +: 2] = op;
  endtask

  // One isolated transaction for requester id; req dropped in the DONE cycle.
  task automatic run_one(input int id, input logic [3:0] a, input logic [3:0] b,
                         input logic [1:0] op, input logic [3:0] exp_res);
    set_ops(id, a, b, op);
    req     = '0;
    req[id] = 1'b1;
    tick();
    chk("run_gnt", 32'(gnt), 32'(1) << id);
    chk("run_busy_e0", 32'(busy), 32'd1);
    chk("run_ack_e0", 32'(ack), 32'd0);
    tick();
    chk("run_valid", 32'(result_valid), 32'd1);
    chk("run_ack", 32'(ack), 32'(1) << id);
    chk("run_result", 32'(result), 32'(exp_res));
    chk("run_id", 32'(result_id), 32'(id));
    req = '0;
    tick();
    chk("run_busy_e2", 32'(busy), 32'd0);
    chk("run_gnt_e2", 32'(gnt), 32'd0);
    chk("run_valid_e2", 32'(result_valid), 32'd0);
    chk("run_hold", 32'(result), 32'(exp_res));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int order [8];
    logic [3:0] res_by_id [4];
    order     = '{0, 1, 2, 3, 0, 1, 2, 0};
    res_by_id = '{4'h8, 4'hE, 4'h6, 4'h7};

    reset = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    op_in = '0;
    tick();
    tick();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_id", 32'(result_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;

    // single request, then all opcodes from requester 2
    run_one(0, 4'hC, 4'hA, 2'b00, 4'h8);
    run_one(2, 4'hC, 4'hA, 2'b00, 4'h8);
    run_one(2, 4'hC, 4'hA, 2'b01, 4'hE);
    run_one(2, 4'hC, 4'hA, 2'b10, 4'h6);
    run_one(2, 4'hC, 4'hA, 2'b11, 4'h7);

    // fairness: all request, requester 3 drops after its first service
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_in  = 16'hCCCC;
    b_in  = 16'hAAAA;
    op_in = 8'b11_10_01_00;
    req   = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) req = 4'b0111;
      tick();
      chk("fair_gnt", 32'(gnt), 32'(1) << order[k]);
      chk("fair_ack_e0", 32'(ack), 32'd0);
      tick();
      chk("fair_ack", 32'(ack), 32'(1) << order[k]);
      chk("fair_result", 32'(result), 32'(res_by_id[order[k]]));
      chk("fair_id", 32'(result_id), 32'(order[k]));
      tick();
      chk("fair_idle_busy", 32'(busy), 32'd0);
      chk("fair_idle_ack", 32'(ack), 32'd0);
    end
    req = '0;
    tick();

    // pointer wrap: after serving 3, requester 0 beats 3
    run_one(3, 4'hC, 4'hA, 2'b11, 4'h7);
    set_ops(0, 4'hC, 4'hA, 2'b00);
    req = 4'b1001;
    tick();
    chk("wrap_gnt", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    chk("wrap_ack", 32'(ack), 32'b0001);
    tick();

    // operand capture: a_in of requester 1 changes after grant
    set_ops(1, 4'hC, 4'hA, 2'b10);
    req = 4'b0010;
    tick();
    chk("cap_gnt", 32'(gnt), 32'b0010);
    a_in[1*W +: W] = 4'hF;
    tick();
    chk("cap_result", 32'(result), 32'h6);
    chk("cap_valid", 32'(result_valid), 32'd1);
    a_in[1*W +: W] = 4'h0;
    req = '0;
    tick();
    chk("cap_hold", 32'(result), 32'h6);
    chk("cap_busy", 32'(busy), 32'd0);

    // reset in EXEC: ptr is 2 before reset, 0 after, so requester 1 wins the retry
    set_ops(1, 4'hC, 4'hA, 2'b01);
    set_ops(2, 4'hC, 4'hA, 2'b00);
    req = 4'b0110;
    tick();
    chk("mid_gnt", 32'(gnt), 32'b0100);
    reset = 1'b1;
    tick();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_ack", 32'(ack), 32'd0);
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_valid", 32'(result_valid), 32'd0);
    chk("mid_rst_id", 32'(result_id), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    tick();
    chk("mid_regnt", 32'(gnt), 32'b0010);
    chk("mid_regnt_ack", 32'(ack), 32'd0);
    tick();
    chk("mid_ack", 32'(ack), 32'b0010);
    chk("mid_result", 32'(result), 32'hE);
    req = '0;
    tick();
    chk("mid_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
